cpu_tstate_sequencer: RTL

//  Timing/run controller for the 4-bit SAP datapath. It generates the one-hot
//  T-state ring that the control decoder uses to drive ep/lp/la/em/li/etc.
//  It also owns run/idle/halt and instruction-boundary handling.

---
 rtl/cpu_tstate_sequencer_pkg.sv | 31 +++
 rtl/cpu_ring_counter.sv | 29 ++
 rtl/cpu_tstate_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_tstate_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_tstate_sequencer_pkg
// Shared definitions for the SAP T-state sequencer:
//   - seq_state_e   : sequencer run-state encoding
//   - tstate_idx_e  : symbolic T-state bit positions (T0 = bit 0)
//   - DEFAULT_N_T / DEFAULT_FETCH_T : default ring length and fetch length
// Optional feature macro used by the sequencer: SEQ_SINGLE_STEP_EN
// ----------------------------------------------------------------------------
package cpu_tstate_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALTED    = 2'd2,
    ST_WAIT_STEP = 2'd3
  } seq_state_e;

  typedef enum int unsigned {
    T0 = 0,
    T1 = 1,
    T2 = 2,
    T3 = 3,
    T4 = 4,
    T5 = 5
  } tstate_idx_e;

  // Six T-states per instruction, of which T0..T2 are the fetch cycles.
  localparam int DEFAULT_N_T     = int'(T5) + 1;
  localparam int DEFAULT_FETCH_T = int'(T3);

endpackage

// File: rtl/cpu_ring_counter.sv
// ----------------------------------------------------------------------------
// cpu_ring_counter
// One-hot N_T-position rotator producing the T-state ring.
// Ports:
//   clk      in      system clock
//   rst      in      synchronous active-high reset, forces T0
//   clear    in      synchronous clear to T0 (wins over advance)
//   advance  in      rotate one position toward the MSB, wrapping to T0
//   tstate   out N_T one-hot T-state, bit0 = T0
// ----------------------------------------------------------------------------
module cpu_ring_counter #(
  parameter int N_T = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [N_T-1:0] tstate
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tstate <= N_T'(1);
    end else if (advance) begin
      tstate <= {tstate[N_T-2:0], tstate[N_T-1]};
    end
  end

endmodule

// File: rtl/cpu_tstate_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_tstate_sequencer
// Timing/run controller for the 4-bit SAP datapath. Generates the one-hot
// T-state ring used by the control decoder, and owns run/idle/halt and
// instruction-boundary handling. The decoder gates every strobe with active.
//
// Parameters:
//   N_T      T-states per instruction (ring length), must be >= FETCH_T+1
//   FETCH_T  T0..FETCH_T-1 are fetch cycles; end_early there is ignored
//   CNT_W    width of the retired-instruction counter
// Ports:
//   clk         in        system clock, posedge
//   rst         in        synchronous active-high reset
//   run         in        1 = execute, 0 = pause at next instruction boundary
//   halt_req    in        decoder saw HLT; latched, takes effect at boundary
//   end_early   in        decoder: current instruction ends at this T-state
//   tstate      out N_T   one-hot T-state, bit0 = T0
//   active      out       1 while running (datapath may load/enable)
//   halted      out       1 in the halted state
//   instr_done  out       combinational: active and instruction ends now
//   instr_cnt   out CNT_W retired-instruction count, wraps
//   step_mode   in        (SEQ_SINGLE_STEP_EN) 1 = one instruction per step
//   step        in        (SEQ_SINGLE_STEP_EN) one-cycle advance pulse
//
// Optional feature: define SEQ_SINGLE_STEP_EN to add single-step operation.
// ----------------------------------------------------------------------------
module cpu_tstate_sequencer
  import cpu_tstate_sequencer_pkg::*;
#(
  parameter int N_T     = DEFAULT_N_T,
  parameter int FETCH_T = DEFAULT_FETCH_T,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             end_early,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic [N_T-1:0]   tstate,
  output logic             active,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_e state;
  logic       halt_latch;
  logic       halt_pending;
  logic       instr_end;
  logic       ring_clear;

  // True when the one-hot T-state lies in the execute window (index >= FETCH_T),
  // the only place an early end is honoured so fetch is never cut short.
  function automatic logic in_exec_window(input logic [N_T-1:0] t);
    return |t[N_T-1:FETCH_T];
  endfunction

  assign instr_end    = tstate[N_T-1] | (end_early & in_exec_window(tstate));
  assign instr_done   = active & instr_end;
  assign halt_pending = halt_latch | halt_req;

  // Any non-running state parks the ring at T0, so re-entering RUN always
  // starts a fresh instruction.
  assign ring_clear = instr_end | ~active;

  cpu_ring_counter #(
    .N_T (N_T)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (ring_clear),
    .advance (active),
    .tstate  (tstate)
  );

  // active/halted are registered alongside state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      active     <= 1'b0;
      halted     <= 1'b0;
      halt_latch <= 1'b0;
      instr_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
`ifdef SEQ_SINGLE_STEP_EN
            if (step_mode) begin
              state  <= ST_WAIT_STEP;
              active <= 1'b0;
            end else begin
              state  <= ST_RUN;
              active <= 1'b1;
            end
`else
            state  <= ST_RUN;
            active <= 1'b1;
`endif
          end
        end

        ST_RUN: begin
          if (halt_req) begin
            halt_latch <= 1'b1;
          end
          if (instr_end) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
            // Boundary priority: halt, then pause, then step wait, else continue.
            if (halt_pending) begin
              state  <= ST_HALTED;
              active <= 1'b0;
              halted <= 1'b1;
            end else if (!run) begin
              state  <= ST_IDLE;
              active <= 1'b0;
            end
`ifdef SEQ_SINGLE_STEP_EN
            else if (step_mode) begin
              state  <= ST_WAIT_STEP;
              active <= 1'b0;
            end
`endif
          end
        end

        ST_HALTED: begin
          // Only rst leaves HALTED.
          state  <= ST_HALTED;
          active <= 1'b0;
          halted <= 1'b1;
        end

`ifdef SEQ_SINGLE_STEP_EN
        ST_WAIT_STEP: begin
          if (!run) begin
            state  <= ST_IDLE;
            active <= 1'b0;
          end else if (step) begin
            state  <= ST_RUN;
            active <= 1'b1;
          end
        end
`endif

        default: begin
          state  <= ST_IDLE;
          active <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
